// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: register-file geometry and
// architecturally special register numbers.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    // Link register written by jal once jumps are added.
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: NUM_REGS-to-1 mux with r0 forced to zero.
// Same-cycle write forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  raddr,
`ifdef REGFILE_BYPASS_EN
    input  logic                               wen,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W-1:0]                  wdata,
`endif
    output logic [DATA_W-1:0]                  rdata
);
    always_comb begin
        rdata = '0;
        if (raddr != ADDR_W'(ZERO_REG)) begin
            rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
            if (wen && waddr == raddr)
                rdata = wdata;
`endif
        end
    end
endmodule

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational read ports, one write port
// committing on the rising edge, synchronous reset. Option: REGFILE_BYPASS_EN.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int NUM_RD = 2;

    // r0 has no storage; it appears only as a constant slot in the read view.
    logic [DATA_W-1:0]                  mem [1:DEPTH-1];
    logic [DEPTH-1:0][DATA_W-1:0]       regs;
    logic [NUM_RD-1:0][ADDR_W-1:0]      raddr;
    logic [NUM_RD-1:0][DATA_W-1:0]      rdata;
    logic                               wen;

    assign wen = reg_write && !reset && (write_reg != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wen) begin
            mem[write_reg] <= write_data;
        end
    end

    always_comb begin
        regs[0] = '0;
        for (int i = 1; i < DEPTH; i++)
            regs[i] = mem[i];
    end

    assign raddr[0]   = read_reg1;
    assign raddr[1]   = read_reg2;
    assign read_data1 = rdata[0];
    assign read_data2 = rdata[1];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .regs  (regs),
            .raddr (raddr[p]),
`ifdef REGFILE_BYPASS_EN
            .wen   (wen),
            .waddr (write_reg),
            .wdata (write_data),
`endif
            .rdata (rdata[p])
        );
    end
endmodule

// File: doc/mips_register_file.md
# mips_register_file

32-entry general-purpose register file for the single-cycle MIPS datapath. It sits directly downstream of the write-register-select and write-data-select multiplexers (RegDst, MemtoReg), which drive its write address and write data. Its two read ports feed the ALU operand path and the ALUSrc multiplexer. Reads are combinational and writes commit on the rising clock edge, so one instruction completes per cycle.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W entries

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears every register at the next rising edge of clk
- reg_write  input  1  write enable from the control unit
- write_reg  input  ADDR_W  destination register, from the RegDst mux
- write_data  input  DATA_W  write-back value, from the MemtoReg mux
- read_reg1  input  ADDR_W  rs address
- read_reg2  input  ADDR_W  rt address
- read_data1  output  DATA_W  contents of read_reg1; combinational
- read_data2  output  DATA_W  contents of read_reg2; combinational

## Operation
- Storage: registers 1..31, each DATA_W wide. Register 0 has no storage; it is hardwired to 0.
- Write: at a rising edge with reset=0, reg_write=1 and write_reg≠0, the register at write_reg takes write_data. All other registers hold.
- Writes to register 0 are silently discarded, with no side effect.
- Reset: at a rising edge with reset=1, all registers clear to 0. Reset has priority over a simultaneous write, so the write is lost.
- Reset asserted mid-program: the clear takes effect at the next edge, with no partial state.
- Read: read_dataN is the contents of register read_regN, with no clock involvement.
- Reading register 0 always returns 0.
- Both read ports may address the same register, and each returns the same value.
- Read-during-write to the same register (without bypass): the read returns the old value until the edge and the new value after it.
- Address decode covers all 2**ADDR_W entries, so there are no out-of-range addresses.
- No X propagation from storage: every register has a defined value after the first reset edge.

## Timing
- Read latency: 0 cycles (combinational from read_reg and storage).
- Write latency: the value is visible on read ports starting the cycle after the edge at which it was written.
- Output values after reset: both read ports return 0 for any address from the cycle following the reset edge, until the next write.
- Before the first reset edge, register contents are undefined. The bench must not check reads in that window.
- The write path has no combinational dependence on the read ports. Read ports depend only on addresses and storage, or also on write inputs when bypass is enabled.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: internal write-to-read forwarding. If reg_write=1, reset=0, write_reg≠0 and read_regN==write_reg, then read_dataN = write_data in the same cycle. This applies to each port independently, and register 0 is still 0.
  - Undefined: no forwarding. A same-cycle read returns the pre-write value.
  - In both builds, state after the edge is identical. Only same-cycle read values differ.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32
  - ZERO_REG = 5'd0
  - REG_RA = 5'd31, for later jal support
- One sub-module, regfile_read_port: a NUM_REGS-to-1 read multiplexer with the zero-register force and the optional bypass compare. It is instantiated twice, once per read port.
- Top-level module contains the storage array, the write decode and the reset clear.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, assert reset for one edge, read r5 on both ports → 0x00000000.
- Basic write/read: write 0x12345678 to r8 and 0xCAFEF00D to r9 on consecutive edges, then read_reg1=8, read_reg2=9 → 0x12345678 / 0xCAFEF00D.
- Zero register: write 0xFFFFFFFF to r0 with reg_write=1, then read r0 on both ports → 0x00000000.
- Write enable low: with reg_write=0, drive write_reg=10, write_data=0xAAAA5555, then read r10 → its prior value, unchanged.
- Read-during-write: with r12=0x00000011, write 0x00000022 to r12 and read r12 in the same cycle.
  - Without REGFILE_BYPASS_EN → 0x00000011 before the edge.
  - With REGFILE_BYPASS_EN → 0x00000022.
  - Both builds → 0x00000022 after the edge.
- Reset vs write collision: assert reset=1 and reg_write=1 with write_reg=31, write_data=0x0000BEEF on the same edge, then read r31 → 0x00000000.
